loba_split_pipe: RTL and testbench

// - Pipelined, parametrised successor to the combinational LOBA operand splitter.
// - Decomposes an unsigned WIDTH-bit operand into NSEG leading-one-anchored SEG-bit segments plus their shift amounts.
// - One segment per pipeline stage, valid/ready handshake on both sides.
// - Sits in front of the LOBA approximate-multiplier partial-product stage.

---
 rtl/loba_pkg.sv | 42 ++++
 rtl/loba_seg_extract.sv | 48 ++++
 rtl/loba_split_pipe.sv | 134 +++++++++++++
 tb/tb_loba_split_pipe.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/loba_pkg.sv
// ----------------------------------------------------------------------------
// loba_pkg
// Shared helpers for the pipelined LOBA operand splitter.
//   loba_kw   : width of a shift field for a given operand width
//   loba_lod  : leading-one detector, returns index plus found flag
//   loba_mask : mask of all bits strictly below a given bit position
// The helpers work on a 64-bit view of the operand, so operands up to 64 bits
// wide are supported.
// ----------------------------------------------------------------------------
package loba_pkg;

    localparam int LOBA_MAXW = 64;

    typedef struct packed {
        logic       found;
        logic [5:0] idx;
    } loba_lod_t;

    // A 1-bit field is kept even for a 1-bit operand so no port collapses
    // to zero width.
    function automatic int loba_kw(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

    // The highest set bit wins because the scan runs upward and overwrites.
    function automatic loba_lod_t loba_lod(input logic [LOBA_MAXW-1:0] r);
        loba_lod_t res;
        res = '0;
        for (int i = 0; i < LOBA_MAXW; i++) begin
            if (r[i]) begin
                res.found = 1'b1;
                res.idx   = 6'(i);
            end
        end
        return res;
    endfunction

    function automatic logic [LOBA_MAXW-1:0] loba_mask(input logic [5:0] lsb);
        return (64'd1 << lsb) - 64'd1;
    endfunction

endpackage

// File: rtl/loba_seg_extract.sv
// ----------------------------------------------------------------------------
// loba_seg_extract
// Combinational single-segment rule of the LOBA splitter.
// Ports:
//   r_i      in   WIDTH  remainder entering this stage
//   seg_o    out  SEG    extracted segment
//   k_o      out  KW     bit position the segment's top bit is anchored at
//   r_next_o out  WIDTH  remainder after removing the segment window
// A remainder whose leading one sits below SEG-1 is taken whole as the low
// SEG bits, anchored at SEG-1, leaving nothing behind.
// ----------------------------------------------------------------------------
module loba_seg_extract
    import loba_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int SEG   = 4,
    parameter int KW    = 4
) (
    input  logic [WIDTH-1:0] r_i,
    output logic [SEG-1:0]   seg_o,
    output logic [KW-1:0]    k_o,
    output logic [WIDTH-1:0] r_next_o
);

    logic [LOBA_MAXW-1:0] r_ext;
    loba_lod_t            lod;
    logic [5:0]           lsb;   // lowest bit of the segment window

    always_comb begin
        r_ext    = LOBA_MAXW'(r_i);
        lod      = loba_lod(r_ext);
        lsb      = lod.idx - 6'(SEG - 1);
        seg_o    = '0;
        k_o      = '0;
        r_next_o = '0;
        if (lod.found) begin
            if (lod.idx < 6'(SEG - 1)) begin
                k_o   = KW'(SEG - 1);
                seg_o = r_i[SEG-1:0];
            end else begin
                k_o      = KW'(lod.idx);
                seg_o    = SEG'(r_ext >> lsb);
                r_next_o = r_i & WIDTH'(loba_mask(lsb));
            end
        end
    end

endmodule

// File: rtl/loba_split_pipe.sv
// ----------------------------------------------------------------------------
// loba_split_pipe
// Pipelined LOBA operand splitter: decomposes an unsigned WIDTH-bit operand
// into NSEG leading-one-anchored SEG-bit segments and their shift amounts,
// one segment per pipeline stage, with valid/ready on both sides.
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   in_valid/in_ready      operand handshake, in_data = operand X
//   out_valid/out_ready    result handshake
//   out_seg                segment i at [i*SEG +: SEG], i=0 most significant
//   out_k                  shift i at [i*KW +: KW]
//   out_zero               operand was zero
//   out_exact              nothing left after the last segment
// Stage i holds valid, remainder, zero flag and segments/shifts 0..i.
// A stage loads when it is empty or its successor loads, so bubbles collapse
// and a full pipeline advances every stage in one cycle.
// ----------------------------------------------------------------------------
module loba_split_pipe
    import loba_pkg::*;
#(
    parameter  int WIDTH = 16,
    parameter  int SEG   = 4,
    parameter  int NSEG  = 2,
    localparam int KW    = loba_kw(WIDTH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [NSEG*SEG-1:0]  out_seg,
    output logic [NSEG*KW-1:0]   out_k,
    output logic                 out_zero,
    output logic                 out_exact
);

    // Index 0 is the input side; index i+1 is the register output of stage i.
    logic                stg_valid [NSEG+1];
    logic [WIDTH-1:0]    stg_rem   [NSEG+1];
    logic                stg_zero  [NSEG+1];
    logic [NSEG*SEG-1:0] stg_seg   [NSEG+1];
    logic [NSEG*KW-1:0]  stg_k     [NSEG+1];
    logic                load_en   [NSEG];

    assign stg_valid[0] = in_valid;
    assign stg_rem[0]   = in_data;
    assign stg_zero[0]  = (in_data == '0);
    assign stg_seg[0]   = '0;
    assign stg_k[0]     = '0;

    // Ready ripples backward from out_ready through every full stage.
    always_comb begin
        for (int i = 0; i < NSEG; i++) begin
            load_en[i] = 1'b0;
        end
        load_en[NSEG-1] = !stg_valid[NSEG] || out_ready;
        for (int i = NSEG - 2; i >= 0; i--) begin
            load_en[i] = !stg_valid[i+1] || load_en[i+1];
        end
    end

    assign in_ready = load_en[0];

    genvar gi;
    generate
        for (gi = 0; gi < NSEG; gi++) begin : g_stage
            logic                valid_q;
            logic [WIDTH-1:0]    rem_q;
            logic [WIDTH-1:0]    rem_d;
            logic                zero_q;
            logic [NSEG*SEG-1:0] seg_q;
            logic [NSEG*SEG-1:0] seg_d;
            logic [NSEG*KW-1:0]  k_q;
            logic [NSEG*KW-1:0]  k_d;
            logic [SEG-1:0]      seg_x;
            logic [KW-1:0]       k_x;

            loba_seg_extract #(
                .WIDTH (WIDTH),
                .SEG   (SEG),
                .KW    (KW)
            ) u_extract (
                .r_i      (stg_rem[gi]),
                .seg_o    (seg_x),
                .k_o      (k_x),
                .r_next_o (rem_d)
            );

            // Carry earlier segments forward and drop this stage's one in.
            always_comb begin
                seg_d                 = stg_seg[gi];
                seg_d[gi*SEG +: SEG]  = seg_x;
                k_d                   = stg_k[gi];
                k_d[gi*KW +: KW]      = k_x;
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    valid_q <= 1'b0;
                    rem_q   <= '0;
                    zero_q  <= 1'b0;
                    seg_q   <= '0;
                    k_q     <= '0;
                end else if (load_en[gi]) begin
                    valid_q <= stg_valid[gi];
                    // Data only moves with a real operand, so bubbles leave
                    // the previous contents untouched.
                    if (stg_valid[gi]) begin
                        rem_q  <= rem_d;
                        zero_q <= stg_zero[gi];
                        seg_q  <= seg_d;
                        k_q    <= k_d;
                    end
                end
            end

            assign stg_valid[gi+1] = valid_q;
            assign stg_rem[gi+1]   = rem_q;
            assign stg_zero[gi+1]  = zero_q;
            assign stg_seg[gi+1]   = seg_q;
            assign stg_k[gi+1]     = k_q;
        end
    endgenerate

    assign out_valid = stg_valid[NSEG];
    assign out_seg   = stg_seg[NSEG];
    assign out_k     = stg_k[NSEG];
    assign out_zero  = stg_zero[NSEG];
    // Qualified by valid so the output reads all-zero out of reset.
    assign out_exact = stg_valid[NSEG] && (stg_rem[NSEG] == '0);

endmodule

// File: tb/tb_loba_split_pipe.sv
module tb_loba_split_pipe;

    localparam int WIDTH = 16;
    localparam int SEG   = 4;
    localparam int NSEG  = 2;
    localparam int KW    = 4;

    logic                clk       = 1'b0;
    logic                rst_n     = 1'b0;
    logic                in_valid  = 1'b0;
    logic                in_ready;
    logic [WIDTH-1:0]    in_data   = '0;
    logic                out_valid;
    logic                out_ready = 1'b0;
    logic [NSEG*SEG-1:0] out_seg;
    logic [NSEG*KW-1:0]  out_k;
    logic                out_zero;
    logic                out_exact;

    loba_split_pipe #(
        .WIDTH (WIDTH),
        .SEG   (SEG),
        .NSEG  (NSEG)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_seg   (out_seg),
        .out_k     (out_k),
        .out_zero  (out_zero),
        .out_exact (out_exact)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] seg;
        logic [7:0] k;
        logic       zero;
        logic       exact;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   err_cnt = 0;
    int   chk_cnt = 0;
    int   out_cnt = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Reference split for WIDTH=16, SEG=4, NSEG=2.
    function automatic exp_t model(input logic [15:0] x);
        exp_t        e;
        logic [15:0] r;
        int          p;
        e      = '0;
        e.zero = (x == 16'd0);
        r      = x;
        for (int i = 0; i < 2; i++) begin
            if (r != 16'd0) begin
                p = 0;
                for (int b = 0; b < 16; b++) if (r[b]) p = b;
                if (p < 3) begin
                    e.seg[i*4 +: 4] = r[3:0];
                    e.k[i*4 +: 4]   = 4'd3;
                    r               = 16'd0;
                end else begin
                    e.seg[i*4 +: 4] = 4'(r >> (p - 3));
                    e.k[i*4 +: 4]   = 4'(p);
                    r               = r & ((16'd1 << (p - 3)) - 16'd1);
                end
            end
        end
        e.exact = (r == 16'd0);
        return e;
    endfunction

    // Output monitor: a transfer happens on the next rising edge.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            check_eq("sb_nonempty", 64'(sb.size() > 0), 64'd1);
            if (sb.size() > 0) begin
                mon_e = sb.pop_front();
                out_cnt++;
                $display("out #%0d: seg=%h k=%h zero=%b exact=%b", out_cnt, out_seg, out_k, out_zero, out_exact);
                check_eq("seg",   64'(out_seg),   64'(mon_e.seg));
                check_eq("k",     64'(out_k),     64'(mon_e.k));
                check_eq("zero",  64'(out_zero),  64'(mon_e.zero));
                check_eq("exact", 64'(out_exact), 64'(mon_e.exact));
            end
        end
    end

    // Call at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send(input logic [15:0] x, input exp_t e);
        bit done;
        done     = 1'b0;
        in_valid = 1'b1;
        in_data  = x;
        for (int c = 0; c < 200 && !done; c++) begin
            @(negedge clk);
            if (in_ready) begin
                sb.push_back(e);
                done = 1'b1;
                $display("in : x=%h", x);
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        check_eq("accept", 64'(done), 64'd1);
    endtask

    task automatic drain();
        for (int c = 0; c < 200 && sb.size() > 0; c++) begin
            @(posedge clk);
            #1;
        end
        check_eq("drain_left", 64'(sb.size()), 64'd0);
    endtask

    initial begin
        int sent;
        bit pend;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_out_valid", 64'(out_valid), 64'd0);
        check_eq("rst_in_ready",  64'(in_ready),  64'd1);
        check_eq("rst_out_seg",   64'(out_seg),   64'd0);
        check_eq("rst_out_k",     64'(out_k),     64'd0);
        check_eq("rst_out_zero",  64'(out_zero),  64'd0);
        check_eq("rst_out_exact", 64'(out_exact), 64'd0);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        #1;
        check_eq("in_ready_after_rst", 64'(in_ready), 64'd1);

        // Directed vectors with latency check on the first
        send(16'hB6A5, '{seg: 8'hDB, k: 8'hAF, zero: 1'b0, exact: 1'b0});
        check_eq("lat_cycle1", 64'(out_valid), 64'd0);
        @(posedge clk);
        #1;
        check_eq("lat_cycle2", 64'(out_valid), 64'd1);
        send(16'h0005, '{seg: 8'h05, k: 8'h03, zero: 1'b0, exact: 1'b1});
        send(16'h0000, '{seg: 8'h00, k: 8'h00, zero: 1'b1, exact: 1'b1});
        send(16'h8000, '{seg: 8'h08, k: 8'h0F, zero: 1'b0, exact: 1'b1});
        drain();

        // Stall: two accepts fill the pipe, then in_ready drops
        out_ready = 1'b0;
        send(16'h0001, model(16'h0001));
        send(16'h0002, model(16'h0002));
        in_valid = 1'b1;
        in_data  = 16'h0003;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check_eq("stall_in_ready",  64'(in_ready),  64'd0);
            check_eq("stall_out_valid", 64'(out_valid), 64'd1);
            check_eq("stall_out_seg",   64'(out_seg),   64'(sb[0].seg));
            check_eq("stall_out_k",     64'(out_k),     64'(sb[0].k));
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        send(16'h0003, model(16'h0003));
        send(16'h0004, model(16'h0004));
        drain();

        // Random stream with random backpressure
        sent = 0;
        pend = 1'b0;
        for (int c = 0; c < 3000 && sent < 40; c++) begin
            out_ready = 1'($urandom_range(0, 1));
            if (!pend && $urandom_range(0, 3) != 0) begin
                pend     = 1'b1;
                in_valid = 1'b1;
                in_data  = ($urandom_range(0, 1) == 1) ? 16'($urandom) : 16'($urandom_range(0, 15));
            end
            @(negedge clk);
            if (pend && in_ready) begin
                sb.push_back(model(in_data));
                $display("in : x=%h", in_data);
                sent++;
                pend = 1'b0;
            end
            @(posedge clk);
            #1;
            if (!pend) in_valid = 1'b0;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check_eq("rand_sent", 64'(sent), 64'd40);
        drain();

        // Reset with two operands in flight
        out_ready = 1'b0;
        send(16'h1234, model(16'h1234));
        send(16'h4321, model(16'h4321));
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("async_rst_out_valid", 64'(out_valid), 64'd0);
        check_eq("async_rst_out_seg",   64'(out_seg),   64'd0);
        check_eq("async_rst_in_ready",  64'(in_ready),  64'd1);
        sb.delete();
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        check_eq("post_rst_in_ready", 64'(in_ready), 64'd1);
        send(16'h00F0, '{seg: 8'h0F, k: 8'h07, zero: 1'b0, exact: 1'b1});
        check_eq("post_rst_lat1", 64'(out_valid), 64'd0);
        @(posedge clk);
        #1;
        check_eq("post_rst_lat2", 64'(out_valid), 64'd1);
        drain();
        repeat (2) @(posedge clk);
        #1;
        check_eq("end_out_valid", 64'(out_valid), 64'd0);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
